// File: rtl/video_out_adapter.sv
// video_out_adapter: output stage between raw arcade-core video and the Pocket video_if.
// Stretches the pixel enable, expands colour to 8 bits per channel, and turns sync
// edges into delayed single-cycle pulses. It also measures the active line width and
// the active frame height.
module video_out_adapter #(
    parameter int unsigned COLOR_BITS     = 4,
    parameter int unsigned CE_HOLD        = 2,
    parameter bit          HS_ACTIVE_HIGH = 1'b1,
    parameter bit          VS_ACTIVE_HIGH = 1'b1,
    parameter int unsigned SYNC_DELAY     = 3,
    parameter int unsigned CNT_WIDTH      = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COLOR_BITS-1:0] r_in,
    input  logic [COLOR_BITS-1:0] g_in,
    input  logic [COLOR_BITS-1:0] b_in,
    input  logic                 hblank,
    input  logic                 vblank,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 ce_pixel,
    input  logic                 force_blank,
    output logic [23:0]          rgb,
    output logic                 de,
    output logic                 skip,
    output logic                 hs,
    output logic                 vs,
    output logic [CNT_WIDTH-1:0] line_width,
    output logic [CNT_WIDTH-1:0] frame_height,
    output logic                 sync_err
);

    localparam int unsigned     PW        = SYNC_DELAY + 1;
    localparam int unsigned     REPS      = 8 / COLOR_BITS + 1;
    localparam logic [2:0]      HOLD_LOAD = 3'(CE_HOLD - 1);

    typedef enum logic {
        GEO_IDLE,
        GEO_ACTIVE
    } geo_state_e;

    // MSB-first replication: repeat the channel until 8 bits are filled, keep the top 8
    function automatic logic [7:0] expand8(input logic [COLOR_BITS-1:0] c);
        logic [REPS*COLOR_BITS-1:0] rep;
        rep = {REPS{c}};
        return rep[REPS*COLOR_BITS-1 -: 8];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    logic [23:0]          rgb_q, rgb_d;
    logic                 de_q, de_d;
    logic                 skip_q, skip_d;
    logic [2:0]           hold_cnt_q, hold_cnt_d;
    logic                 hs_prev_q, hs_prev_d;
    logic                 vs_prev_q, vs_prev_d;
    logic [PW-1:0]        hs_pipe_q, hs_pipe_d;
    logic [PW-1:0]        vs_pipe_q, vs_pipe_d;
    logic                 sync_err_q, sync_err_d;
    geo_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] line_width_q, line_width_d;
    logic [CNT_WIDTH-1:0] frame_height_q, frame_height_d;

    logic                 ce_held;
    logic                 hs_norm, vs_norm;
    logic                 pix_valid;
    logic                 line_close;
    logic [CNT_WIDTH-1:0] line_cnt_inc;

    // Next-state logic for pixel path, sync pulses and geometry measurement
    always_comb begin
        // pixel enable stretch
        ce_held    = ce_pixel | (hold_cnt_q != '0);
        hold_cnt_d = hold_cnt_q;
        if (ce_pixel) begin
            hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 3'd1;
        end

        // registered pixel path
        de_d   = ~(hblank | vblank);
        skip_d = de_d & ~ce_held;
        rgb_d  = '0;
        if (de_d && !force_blank) begin
            rgb_d = {expand8(r_in), expand8(g_in), expand8(b_in)};
        end

        // sync: normalise polarity, take the rising edge, shift through the delay line
        hs_norm    = HS_ACTIVE_HIGH ? hsync : ~hsync;
        vs_norm    = VS_ACTIVE_HIGH ? vsync : ~vsync;
        hs_prev_d  = hs_norm;
        vs_prev_d  = vs_norm;
        hs_pipe_d  = (hs_pipe_q << 1) | PW'(hs_norm & ~hs_prev_q);
        vs_pipe_d  = (vs_pipe_q << 1) | PW'(vs_norm & ~vs_prev_q);
        // flag an hs pulse landing on an active-video cycle, aligned with the pulse itself
        sync_err_d = sync_err_q | (hs_pipe_d[PW-1] & de_d);

        // geometry: count qualified pixels per line, lines per frame
        pix_valid      = de_q & ~skip_q;
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        line_width_d   = line_width_q;
        frame_height_d = frame_height_q;
        line_close     = 1'b0;
        case (state_q)
            GEO_IDLE: begin
                if (de_q) begin
                    state_d   = GEO_ACTIVE;
                    pix_cnt_d = sat_inc('0, pix_valid);
                end
            end
            GEO_ACTIVE: begin
                if (de_q) begin
                    pix_cnt_d = sat_inc(pix_cnt_q, pix_valid);
                end else begin
                    state_d      = GEO_IDLE;
                    line_width_d = pix_cnt_q;
                    line_close   = 1'b1;
                end
            end
            default: state_d = GEO_IDLE;
        endcase

        // a line closing in the same cycle as vs still belongs to the frame being reported
        line_cnt_inc = sat_inc(line_cnt_q, line_close);
        if (vs_pipe_q[PW-1]) begin
            frame_height_d = line_cnt_inc;
            line_cnt_d     = '0;
        end else begin
            line_cnt_d     = line_cnt_inc;
        end
    end

    // State registers; asynchronous reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q          <= '0;
            de_q           <= 1'b0;
            skip_q         <= 1'b0;
            hold_cnt_q     <= '0;
            hs_prev_q      <= 1'b0;
            vs_prev_q      <= 1'b0;
            hs_pipe_q      <= '0;
            vs_pipe_q      <= '0;
            sync_err_q     <= 1'b0;
            state_q        <= GEO_IDLE;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            line_width_q   <= '0;
            frame_height_q <= '0;
        end else begin
            rgb_q          <= rgb_d;
            de_q           <= de_d;
            skip_q         <= skip_d;
            hold_cnt_q     <= hold_cnt_d;
            hs_prev_q      <= hs_prev_d;
            vs_prev_q      <= vs_prev_d;
            hs_pipe_q      <= hs_pipe_d;
            vs_pipe_q      <= vs_pipe_d;
            sync_err_q     <= sync_err_d;
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            line_width_q   <= line_width_d;
            frame_height_q <= frame_height_d;
        end
    end

    assign rgb          = rgb_q;
    assign de           = de_q;
    assign skip         = skip_q;
    assign hs           = hs_pipe_q[PW-1];
    assign vs           = vs_pipe_q[PW-1];
    assign line_width   = line_width_q;
    assign frame_height = frame_height_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_video_out_adapter.sv
// Directed bench for video_out_adapter: a default instance (4-bit colour, active-high
// syncs, 3-cycle sync delay) and a second instance (5-bit colour, active-low syncs,
// no sync delay, 8-bit counters) driven side by side.
module tb_video_out_adapter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] r_a, g_a, b_a;
    logic [4:0] r_b, g_b, b_b;
    logic       hblank, vblank, ce_pixel, force_blank;
    logic       hsync_a, vsync_a, hsync_b, vsync_b;

    logic [23:0] rgb_a, rgb_b;
    logic        de_a, skip_a, hs_a, vs_a, err_a;
    logic        de_b, skip_b, hs_b, vs_b, err_b;
    logic [11:0] lw_a, fh_a;
    logic [7:0]  lw_b, fh_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    video_out_adapter #(
        .COLOR_BITS(4), .CE_HOLD(2), .HS_ACTIVE_HIGH(1'b1), .VS_ACTIVE_HIGH(1'b1),
        .SYNC_DELAY(3), .CNT_WIDTH(12)
    ) dut_a (
        .clk(clk), .reset(reset), .r_in(r_a), .g_in(g_a), .b_in(b_a),
        .hblank(hblank), .vblank(vblank), .hsync(hsync_a), .vsync(vsync_a),
        .ce_pixel(ce_pixel), .force_blank(force_blank),
        .rgb(rgb_a), .de(de_a), .skip(skip_a), .hs(hs_a), .vs(vs_a),
        .line_width(lw_a), .frame_height(fh_a), .sync_err(err_a)
    );

    video_out_adapter #(
        .COLOR_BITS(5), .CE_HOLD(2), .HS_ACTIVE_HIGH(1'b0), .VS_ACTIVE_HIGH(1'b0),
        .SYNC_DELAY(0), .CNT_WIDTH(8)
    ) dut_b (
        .clk(clk), .reset(reset), .r_in(r_b), .g_in(g_b), .b_in(b_b),
        .hblank(hblank), .vblank(vblank), .hsync(hsync_b), .vsync(vsync_b),
        .ce_pixel(ce_pixel), .force_blank(force_blank),
        .rgb(rgb_b), .de(de_b), .skip(skip_b), .hs(hs_b), .vs(vs_b),
        .line_width(lw_b), .frame_height(fh_b), .sync_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hblank = 1'b1; vblank = 1'b0; ce_pixel = 1'b0; force_blank = 1'b0;
        hsync_a = 1'b0; vsync_a = 1'b0; hsync_b = 1'b1; vsync_b = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // one line: 4 active cycles then 2 blank cycles
    task automatic run_line();
        hblank = 1'b0;
        repeat (4) tick();
        hblank = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        r_a = 4'hA; g_a = 4'h5; b_a = 4'hF;
        r_b = 5'b10110; g_b = 5'b00001; b_b = 5'b11111;
        do_reset();
        reset = 1'b1;
        tick();

        // reset state
        chk("rst_rgb", 32'(rgb_a), 32'h0);
        chk("rst_de", 32'(de_a), 32'h0);
        chk("rst_lw", 32'(lw_a), 32'h0);
        chk("rst_fh", 32'(fh_a), 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        reset = 1'b0;

        // colour expansion and force_blank
        hblank = 1'b0; ce_pixel = 1'b1;
        tick();
        chk("de_on", 32'(de_a), 32'h1);
        chk("rgb_a", 32'(rgb_a), 32'hAA55FF);
        chk("rgb_b", 32'(rgb_b), 32'hB508FF);
        chk("skip_ce", 32'(skip_a), 32'h0);
        force_blank = 1'b1;
        tick();
        chk("fb_rgb_a", 32'(rgb_a), 32'h0);
        chk("fb_rgb_b", 32'(rgb_b), 32'h0);
        chk("fb_de", 32'(de_a), 32'h1);
        force_blank = 1'b0;
        tick();
        chk("rgb_back", 32'(rgb_a), 32'hAA55FF);
        hblank = 1'b1;
        tick();
        chk("de_off", 32'(de_a), 32'h0);
        chk("rgb_blank", 32'(rgb_a), 32'h0);
        tick();
        chk("lw_short", 32'(lw_a), 32'd3);

        // asynchronous reset mid-line, then a fresh line
        hblank = 1'b0;
        repeat (37) tick();
        chk("pre_rst_de", 32'(de_a), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_de", 32'(de_a), 32'h0);
        chk("mid_rst_rgb", 32'(rgb_a), 32'h0);
        chk("mid_rst_lw", 32'(lw_a), 32'h0);
        chk("mid_rst_skip", 32'(skip_a), 32'h0);
        #1;
        reset = 1'b0;
        repeat (10) tick();
        hblank = 1'b1;
        tick();
        tick();
        chk("lw_after_rst", 32'(lw_a), 32'd10);

        // CE stretch: ce every 4th cycle across 640 active cycles
        do_reset();
        for (int j = 0; j < 640; j++) begin
            hblank = 1'b0;
            ce_pixel = (j % 4 == 0);
            tick();
            if (j < 8) chk($sformatf("skip_%0d", j), 32'(skip_a), 32'((j % 4) >= 2));
        end
        hblank = 1'b1; ce_pixel = 1'b0;
        tick();
        tick();
        chk("lw_320", 32'(lw_a), 32'd320);
        chk("lw_b_sat320", 32'(lw_b), 32'd255);

        // 300-pixel line: saturates the 8-bit counter
        ce_pixel = 1'b1; hblank = 1'b0;
        repeat (300) tick();
        hblank = 1'b1;
        tick();
        tick();
        chk("lw_300", 32'(lw_a), 32'd300);
        chk("lw_b_sat300", 32'(lw_b), 32'd255);

        // sync delay: edge at cycle 100 appears on hs 4 cycles later
        do_reset();
        repeat (99) tick();
        hsync_a = 1'b1; hsync_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("hs_dly_%0d", k), 32'(hs_a), 32'(k == 4));
            chk($sformatf("hs_b_%0d", k), 32'(hs_b), 32'(k == 1));
        end
        hsync_a = 1'b0; hsync_b = 1'b1;
        repeat (6) tick();
        // edges two cycles apart each give their own pulse
        for (int s = 0; s < 8; s++) begin
            hsync_a = (s == 0) || (s == 2);
            tick();
            chk($sformatf("hs_close_%0d", s), 32'(hs_a), 32'((s == 3) || (s == 5)));
        end
        hsync_a = 1'b0;

        // sync_err: pulse landing in blank vs. pulse landing in active video
        do_reset();
        for (int s = 0; s < 28; s++) begin
            hblank = (s >= 20);
            hsync_a = (s >= 18) && (s < 22);
            tick();
            if (s == 21) chk("hs_in_blank", 32'(hs_a), 32'h1);
        end
        chk("err_clear", 32'(err_a), 32'h0);
        for (int s = 0; s < 28; s++) begin
            hblank = (s >= 20);
            hsync_a = (s >= 15) && (s < 19);
            tick();
            if (s == 18) chk("hs_in_active", 32'(hs_a), 32'h1);
        end
        chk("err_set", 32'(err_a), 32'h1);
        repeat (10) tick();
        chk("err_sticky", 32'(err_a), 32'h1);
        do_reset();
        chk("err_reset", 32'(err_a), 32'h0);

        // frame geometry: two frames of 224 lines each
        for (int f = 0; f < 2; f++) begin
            vblank = 1'b0;
            repeat (224) run_line();
            vblank = 1'b1;
            repeat (3) tick();
            vsync_a = 1'b1; vsync_b = 1'b0;
            tick();
            chk($sformatf("vs_b_f%0d", f), 32'(vs_b), 32'h1);
            chk($sformatf("vs_a_early_f%0d", f), 32'(vs_a), 32'h0);
            vsync_a = 1'b0; vsync_b = 1'b1;
            for (int k = 2; k <= 5; k++) begin
                tick();
                chk($sformatf("vs_a_f%0d_%0d", f, k), 32'(vs_a), 32'(k == 4));
            end
            tick();
            chk($sformatf("fh_a_f%0d", f), 32'(fh_a), 32'd224);
            chk($sformatf("fh_b_f%0d", f), 32'(fh_b), 32'd224);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
